perf_monitor: RTL and testbench

//   Parametrised run monitor for the simulated core. Counts cycles and NUM_EVT

---
 rtl/perf_monitor.sv | 64 ++++++
 tb/tb_perf_monitor.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/perf_monitor.sv
// perf_monitor: cycle/event run monitor with halt/timeout freeze and registered readout
module perf_monitor #(
   parameter int unsigned NUM_EVT    = 4,
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned MAX_CYCLES = 100000,
   parameter bit          SATURATE   = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               isHalt,
   input  logic [NUM_EVT-1:0] evt_v,
   input  logic               freeze,
   input  logic               clear,
   input  logic [3:0]         rd_sel,
   output logic [CNT_W-1:0]   rd_data,
   output logic [CNT_W-1:0]   cycle,
   output logic [NUM_EVT:0]   ovf,
   output logic [1:0]         state,
   output logic               done,
   output logic               timeout
);
   typedef enum logic [1:0] {RUN = 2'd0, HALTED = 2'd1, TMO = 2'd2} st_t;
   localparam int unsigned W = CNT_W > 32 ? CNT_W : 32;
   st_t st, st_nxt;
   logic [CNT_W-1:0] cnt     [NUM_EVT+1];
   logic [CNT_W-1:0] cnt_nxt [NUM_EVT+1];
   logic [NUM_EVT:0] inc, ovf_nxt;
   logic [CNT_W-1:0] rd_mux;
   logic hit, cnt_en;
   always_comb begin
      hit = MAX_CYCLES != 0 && W'(cnt[0]) == W'(MAX_CYCLES);
      st_nxt = st;
      if (st == RUN) st_nxt = isHalt ? HALTED : hit ? TMO : RUN;
      cnt_en = st == RUN && !freeze && (isHalt || !hit);
      inc = {evt_v, 1'b1} & {(NUM_EVT+1){cnt_en}};
      ovf_nxt = ovf;
      rd_mux = '0;
      for (int i = 0; i <= NUM_EVT; i++) begin
         cnt_nxt[i] = cnt[i];
         if (inc[i]) begin
            cnt_nxt[i] = &cnt[i] ? (SATURATE ? cnt[i] : '0) : cnt[i] + CNT_W'(1);
            ovf_nxt[i] = ovf[i] | &cnt[i];
         end
         if (int'(rd_sel) == i) rd_mux = cnt[i];
      end
   end
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         st <= RUN;
         ovf <= '0;
         rd_data <= '0;
         for (int i = 0; i <= NUM_EVT; i++) cnt[i] <= '0;
      end else begin
         st <= st_nxt;
         ovf <= ovf_nxt;
         rd_data <= rd_mux;
         for (int i = 0; i <= NUM_EVT; i++) cnt[i] <= cnt_nxt[i];
      end
   end
   assign cycle   = cnt[0];
   assign state   = st;
   assign done    = st != RUN;
   assign timeout = st == TMO;
endmodule

// File: tb/tb_perf_monitor.sv
// tb_perf_monitor: directed table and sequence checks of perf_monitor in three configurations
module tb_perf_monitor;
   typedef struct packed {
      logic rst, clr, halt, frz;
      logic [3:0] evt, sel;
      logic [7:0] e_cyc;
      logic [1:0] e_st;
      logic [7:0] e_rd;
   } vec_t;
   localparam int N = 23;
   logic clk = 1'b0, reset = 1'b1, clear = 1'b0, is_halt = 1'b0, freeze = 1'b0;
   logic [3:0] evt_v = '0, rd_sel = '0;
   logic [31:0] rd_a, cyc_a;
   logic [3:0] rd_b, cyc_b, rd_c, cyc_c;
   logic [4:0] ovf_a, ovf_b, ovf_c;
   logic [1:0] st_a, st_b, st_c;
   logic done_a, done_b, done_c, tmo_a, tmo_b, tmo_c;
   int n_chk = 0, n_err = 0;
   vec_t tv [N];
   always #5 clk = ~clk;
   perf_monitor #(.NUM_EVT(4), .CNT_W(32), .MAX_CYCLES(20), .SATURATE(1'b1)) dut_a (
      .clk(clk), .reset(reset), .isHalt(is_halt), .evt_v(evt_v), .freeze(freeze), .clear(clear),
      .rd_sel(rd_sel), .rd_data(rd_a), .cycle(cyc_a), .ovf(ovf_a), .state(st_a), .done(done_a), .timeout(tmo_a));
   perf_monitor #(.NUM_EVT(4), .CNT_W(4), .MAX_CYCLES(0), .SATURATE(1'b1)) dut_b (
      .clk(clk), .reset(reset), .isHalt(is_halt), .evt_v(evt_v), .freeze(freeze), .clear(clear),
      .rd_sel(rd_sel), .rd_data(rd_b), .cycle(cyc_b), .ovf(ovf_b), .state(st_b), .done(done_b), .timeout(tmo_b));
   perf_monitor #(.NUM_EVT(4), .CNT_W(4), .MAX_CYCLES(0), .SATURATE(1'b0)) dut_c (
      .clk(clk), .reset(reset), .isHalt(is_halt), .evt_v(evt_v), .freeze(freeze), .clear(clear),
      .rd_sel(rd_sel), .rd_data(rd_c), .cycle(cyc_c), .ovf(ovf_c), .state(st_c), .done(done_c), .timeout(tmo_c));
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask
   function automatic vec_t row(input int r, c, h, f, e, s, ec, es, er);
      row.rst = r[0];
      row.clr = c[0];
      row.halt = h[0];
      row.frz = f[0];
      row.evt = e[3:0];
      row.sel = s[3:0];
      row.e_cyc = ec[7:0];
      row.e_st = es[1:0];
      row.e_rd = er[7:0];
   endfunction
   initial begin
      // freeze/read sweep, freeze+halt, clear and reset+clear on dut_a
      tv[0]  = row(1,0,0,0,4'h4, 0,0,0,0);
      tv[1]  = row(0,0,0,0,4'h4, 0,1,0,0);
      tv[2]  = row(0,0,0,1,4'h4, 3,1,0,1);
      tv[3]  = row(0,0,0,0,4'h4, 0,2,0,1);
      tv[4]  = row(0,0,0,1,4'h4, 3,2,0,2);
      tv[5]  = row(0,0,0,0,4'h4, 1,3,0,0);
      tv[6]  = row(0,0,0,0,4'h4, 3,4,0,3);
      tv[7]  = row(0,0,0,1,4'h4, 5,4,0,0);
      tv[8]  = row(0,0,0,0,4'h4, 0,5,0,4);
      tv[9]  = row(0,0,0,1,4'h0, 0,5,0,5);
      tv[10] = row(0,0,0,1,4'h0, 1,5,0,0);
      tv[11] = row(0,0,0,1,4'h0, 2,5,0,0);
      tv[12] = row(0,0,0,1,4'h0, 3,5,0,5);
      tv[13] = row(0,0,0,1,4'h0, 4,5,0,0);
      tv[14] = row(0,0,0,1,4'h0, 5,5,0,0);
      tv[15] = row(0,0,0,1,4'h0,15,5,0,0);
      tv[16] = row(0,0,1,1,4'h4, 3,5,1,5);
      tv[17] = row(0,0,0,0,4'hF, 0,5,1,5);
      tv[18] = row(0,1,0,0,4'hF, 0,0,0,0);
      tv[19] = row(0,0,0,0,4'hF, 1,1,0,0);
      tv[20] = row(0,0,0,0,4'hF, 1,2,0,1);
      tv[21] = row(1,1,1,0,4'hF, 1,0,0,0);
      tv[22] = row(0,0,0,0,4'h0, 0,1,0,0);
      tick();
      tick();
      chk("reset cycle", cyc_a, 0);
      chk("reset state", 32'(st_a), 0);
      chk("reset ovf", 32'(ovf_a), 0);
      chk("reset done", 32'(done_a), 0);
      chk("reset timeout", 32'(tmo_a), 0);
      chk("reset rd_data", rd_a, 0);
      reset = 1'b0;
      for (int k = 0; k < 10; k++) begin
         evt_v = (k % 2 == 0) ? 4'b0011 : 4'b0001;
         tick();
      end
      chk("t1 pre-halt cycle", cyc_a, 10);
      chk("t1 pre-halt state", 32'(st_a), 0);
      is_halt = 1'b1;
      evt_v = 4'b0011;
      tick();
      is_halt = 1'b0;
      evt_v = 4'b1111;
      chk("t1 halted state", 32'(st_a), 1);
      chk("t1 halted cycle", cyc_a, 11);
      chk("t1 done", 32'(done_a), 1);
      chk("t1 timeout", 32'(tmo_a), 0);
      repeat (5) tick();
      chk("t1 frozen cycle", cyc_a, 11);
      chk("t1 frozen state", 32'(st_a), 1);
      rd_sel = 4'd1;
      tick();
      chk("t1 ch0", rd_a, 11);
      rd_sel = 4'd2;
      tick();
      chk("t1 ch1", rd_a, 6);
      rd_sel = 4'd3;
      tick();
      chk("t1 ch2", rd_a, 0);
      rd_sel = 4'd0;
      evt_v = 4'b0000;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t3 reset-halted cycle", cyc_a, 0);
      chk("t3 reset-halted state", 32'(st_a), 0);
      chk("t3 reset-halted rd", rd_a, 0);
      chk("t3 reset-halted done", 32'(done_a), 0);
      rd_sel = 4'd2;
      tick();
      chk("t3 reset-halted ch1", rd_a, 0);
      rd_sel = 4'd0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (20) tick();
      chk("t2 cycle at limit", cyc_a, 20);
      chk("t2 state at limit", 32'(st_a), 0);
      tick();
      chk("t2 timeout state", 32'(st_a), 2);
      chk("t2 timeout flag", 32'(tmo_a), 1);
      chk("t2 done", 32'(done_a), 1);
      chk("t2 cycle held", cyc_a, 20);
      is_halt = 1'b1;
      tick();
      is_halt = 1'b0;
      chk("t2 late halt state", 32'(st_a), 2);
      chk("t2 late halt cycle", cyc_a, 20);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (20) tick();
      is_halt = 1'b1;
      evt_v = 4'b0001;
      tick();
      is_halt = 1'b0;
      evt_v = 4'b0000;
      chk("t3 halt-vs-limit state", 32'(st_a), 1);
      chk("t3 halt-vs-limit cycle", cyc_a, 21);
      rd_sel = 4'd1;
      tick();
      chk("t3 halt-edge ch0", rd_a, 1);
      for (int k = 0; k < N; k++) begin
         reset = tv[k].rst;
         clear = tv[k].clr;
         is_halt = tv[k].halt;
         freeze = tv[k].frz;
         evt_v = tv[k].evt;
         rd_sel = tv[k].sel;
         tick();
         chk($sformatf("row%0d cycle", k), cyc_a, 32'(tv[k].e_cyc));
         chk($sformatf("row%0d state", k), 32'(st_a), 32'(tv[k].e_st));
         chk($sformatf("row%0d rd_data", k), rd_a, 32'(tv[k].e_rd));
      end
      reset = 1'b0;
      clear = 1'b0;
      is_halt = 1'b0;
      freeze = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      evt_v = 4'b0001;
      rd_sel = 4'd1;
      repeat (20) tick();
      evt_v = 4'b0000;
      freeze = 1'b1;
      tick();
      chk("t4 sat cycle", 32'(cyc_b), 15);
      chk("t4 sat ch0", 32'(rd_b), 15);
      chk("t4 sat ovf", 32'(ovf_b), 3);
      chk("t4 sat state", 32'(st_b), 0);
      chk("t4 wrap cycle", 32'(cyc_c), 4);
      chk("t4 wrap ch0", 32'(rd_c), 4);
      chk("t4 wrap ovf", 32'(ovf_c), 3);
      freeze = 1'b0;
      clear = 1'b1;
      evt_v = 4'b1111;
      tick();
      clear = 1'b0;
      chk("t6 clear ovf sat", 32'(ovf_b), 0);
      chk("t6 clear ovf wrap", 32'(ovf_c), 0);
      chk("t6 clear cycle", 32'(cyc_c), 0);
      chk("t6 clear rd", 32'(rd_c), 0);
      tick();
      chk("t6 resume cycle wrap", 32'(cyc_c), 1);
      chk("t6 resume cycle sat", 32'(cyc_b), 1);
      chk("t6 resume rd pre", 32'(rd_c), 0);
      tick();
      chk("t6 resume ch0", 32'(rd_c), 1);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
